// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the fetch slice: opcodes, reset PC, NOP encoding
// and the fetch FSM state encoding.
package riscv_pkg;

    localparam logic [31:0] RISCV_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] RISCV_NOP      = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_VALID = 2'd2,
        FETCH_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential PC+4 or a single redirect target.
// With FETCH_MISALIGN_TRAP_EN the raw target is kept and flagged when misaligned.
module next_pc_calc
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  branch,
    input  logic                  pc_update,
    input  logic                  pc_target_src,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic                  target_misaligned,
`endif
    output logic [DATA_WIDTH-1:0] pc_plus4,
    output logic [DATA_WIDTH-1:0] next_pc
);

    logic                  redirect;
    logic [DATA_WIDTH-1:0] target_raw;

    assign redirect   = branch | pc_update;
    assign pc_plus4   = pc + DATA_WIDTH'(4);
    // JALR target: LSB cleared before any alignment check
    assign target_raw = pc_target_src ? (alu_result & ~DATA_WIDTH'(1))
                                      : (pc + imm);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_misaligned = redirect && (target_raw[1:0] != 2'b00);
    assign next_pc           = redirect ? target_raw : pc_plus4;
`else
    assign next_pc = redirect ? (target_raw & ~DATA_WIDTH'(3)) : pc_plus4;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: request/wait/hold handshake with instruction memory
// and PC update on retire. Optional trap on misaligned redirect: FETCH_MISALIGN_TRAP_EN.
//
// state       | meaning
// ------------+---------------------------------------------------------
// FETCH_REQ   | issue imem request at pc
// FETCH_WAIT  | request outstanding, address held until imem_ack
// FETCH_VALID | instruction held for execute, waits for instr_ready
// FETCH_HALT  | misaligned redirect trapped, left only by reset
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RISCV_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  branch,
    input  logic                  pc_update,
    input  logic                  pc_target_src,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [DATA_WIDTH-1:0] alu_result,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic                  misaligned,
`endif
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_plus4
);

    fetch_state_t          state, state_nxt;
    logic                  capture;
    logic                  retire;
    logic                  req_st;
    logic                  trap;
    logic [DATA_WIDTH-1:0] next_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic target_misaligned;
    logic misaligned_q;

    assign trap       = target_misaligned;
    assign misaligned = misaligned_q;
`else
    assign trap = 1'b0;
`endif

    next_pc_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_next_pc_calc (
        .pc                (pc),
        .imm               (imm),
        .alu_result        (alu_result),
        .branch            (branch),
        .pc_update         (pc_update),
        .pc_target_src     (pc_target_src),
`ifdef FETCH_MISALIGN_TRAP_EN
        .target_misaligned (target_misaligned),
`endif
        .pc_plus4          (pc_plus4),
        .next_pc           (next_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH_REQ;
            pc    <= RESET_PC;
            instr <= DATA_WIDTH'(RISCV_NOP);
        end else begin
            state <= state_nxt;
            if (capture) instr <= imem_rdata;
            if (retire)  pc    <= next_pc;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                misaligned_q <= 1'b0;
        else if (retire && trap)   misaligned_q <= 1'b1;
    end
`endif

    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        retire      = 1'b0;
        req_st      = 1'b0;
        instr_valid = 1'b0;
        case (state)
            FETCH_REQ: begin
                req_st = 1'b1;
                if (imem_ack) begin
                    capture   = 1'b1;
                    state_nxt = FETCH_VALID;
                end else begin
                    state_nxt = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                req_st = 1'b1;
                if (imem_ack) begin
                    capture   = 1'b1;
                    state_nxt = FETCH_VALID;
                end
            end
            FETCH_VALID: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    retire    = 1'b1;
                    state_nxt = trap ? FETCH_HALT : FETCH_REQ;
                end
            end
            FETCH_HALT: state_nxt = FETCH_HALT;
            default:    state_nxt = FETCH_REQ;
        endcase
    end

    // No request may escape while reset is held, even though state already reads REQ
    assign imem_req  = req_st & reset;
    assign imem_addr = pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000: PC value loaded on reset.
REQ-002 Parameter DATA_WIDTH, default 32: width of PC, instruction, immediate and ALU result.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word address of request, equal to pc.
REQ-007 imem_ack  input  1  memory has imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr  output  32  held instruction; opcode [6:0], funct3 [14:12] and funct7 [31:25] feed the control decoder.
REQ-010 instr_valid  output  1  instr/pc valid for the execute side.
REQ-011 instr_ready  input  1  execute side retires the instruction this cycle.
REQ-012 branch, pc_update, pc_target_src  input  1 each  decoder redirect controls, sampled on retire.
REQ-013 imm, alu_result  input  32 each  redirect operands.
REQ-014 pc, pc_plus4  output  32 each  current PC and PC+4 (JAL/JALR link value).
REQ-015 misaligned  output  1  sticky fault flag; present only with FETCH_MISALIGN_TRAP_EN.

Function
REQ-016 FSM states: REQ, WAIT, VALID, HALT; reset state REQ.
REQ-017 REQ: imem_req=1; imem_ack -> capture imem_rdata into instr, go VALID; otherwise go WAIT.
REQ-018 WAIT: imem_req=1, address held; imem_ack -> capture, go VALID.
REQ-019 Fetch latency: instr_valid rises exactly one cycle after the imem_ack cycle.
REQ-020 VALID: instr_valid=1, imem_req=0; instr, pc and pc_plus4 stable until retire (instr_valid && instr_ready).
REQ-021 On retire, pc loads next_pc and FSM goes to REQ.
REQ-022 next_pc = pc+4 when branch=0 and pc_update=0.
REQ-023 With branch=1 or pc_update=1 (both high: single redirect): pc_target_src=0 -> pc+imm; pc_target_src=1 -> {alu_result[31:1],1'b0}.
REQ-024 All additions are modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-025 Redirect inputs are ignored outside the retire cycle.
REQ-026 imem_ack outside REQ/WAIT is ignored.
REQ-027 HALT: imem_req=0, instr_valid=0; exited only by reset.

Reset
REQ-028 Reset asserted: pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, misaligned=0, state=REQ.
REQ-029 Reset asserted mid-WAIT abandons the request; the first cycle after deassertion issues RESET_PC.

Configuration
REQ-030 Macro FETCH_MISALIGN_TRAP_EN defined: a redirect target with [1:0]!=0 sets misaligned, leaves pc at the faulting target and enters HALT.
REQ-031 Macro undefined: target[1:0] forced to 2'b00, no misaligned port, HALT unreachable.

Structure
REQ-032 Shared package riscv_pkg holds the opcode constants, RESET_PC default, NOP encoding and the fetch-state enumeration.
REQ-033 Combinational sub-module next_pc_calc computes next_pc and the misalignment flag.

Verification
REQ-034 Reset, ack every second cycle, instr_ready=1, no redirect -> imem_addr 0x00400000, 0x00400004, 0x00400008.
REQ-035 Retire with branch=1, pc_target_src=0, pc=0x00400010, imm=0xFFFFFFF8 -> next imem_addr 0x00400008.
REQ-036 Retire with pc_update=1, pc_target_src=1, alu_result=0x00400021 -> imem_addr 0x00400020; pc_plus4 was 0x...+4 of the JALR PC.
REQ-037 instr_valid high with instr_ready=0 for 5 cycles -> instr/pc unchanged, imem_req=0.
REQ-038 Reset pulse during WAIT -> next request at 0x00400000, late ack ignored.
REQ-039 Macro on, redirect target 0x00400022 -> misaligned=1, HALT, no imem_req; macro off -> fetch at 0x00400020.
